tone_reg_scheduler: RTL

//  Sits between the SPI command decoder and the tone voice engine. Queues decoded

---
 rtl/tone_pkg.sv | 18 +
 rtl/reg_write_fifo.sv | 59 +++++
 rtl/tone_reg_scheduler.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/tone_pkg.sv
// Shared constants and state type for the tone register scheduler.
package tone_pkg;

  localparam int WORD_W = 16;
  localparam int ADDR_W = 4;

  // Queue entries carrying these addresses are control operations rather than
  // register writes.
  localparam logic [ADDR_W-1:0] ADDR_OVF_CLR = 4'hE;
  localparam logic [ADDR_W-1:0] ADDR_COMMIT  = 4'hF;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TICK = 2'd1,
    COPY      = 2'd2
  } state_e;

endpackage

// File: rtl/reg_write_fifo.sv
// Small synchronous FIFO holding decoded {addr,data} register writes.
// The full flag is the registered occupancy, so a push into a full queue is
// refused even when a pop happens in the same cycle.
module reg_write_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 20,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic [LVL_W-1:0] level_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

  // Storage needs no reset; occupancy and pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/tone_reg_scheduler.sv
// Queues decoded register writes, drains them into shadow registers, and on a
// commit copies every shadow into the active array starting at the next sample
// tick so all channels change on the same frame boundary.
//
//  state     | meaning
//  IDLE      | draining the write queue, one entry per cycle
//  WAIT_TICK | commit popped; drain halted until the next sample tick
//  COPY      | shadow[idx] -> active[idx] on cycles the engine is not reading
module tone_reg_scheduler
  import tone_pkg::*;
#(
  parameter  int NUM_CH     = 4,
  parameter  int FIFO_DEPTH = 4,
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk_in,
  input  logic              reset_n_in,
  input  logic [ADDR_W-1:0] wr_addr_in,
  input  logic [WORD_W-1:0] wr_data_in,
  input  logic              wr_valid_in,
  input  logic              sample_tick_in,
  input  logic              rd_req_in,
  input  logic [ADDR_W-1:0] rd_addr_in,
  output logic [WORD_W-1:0] rd_data_out,
  output logic              rd_valid_out,
  output logic              commit_busy_out,
  output logic              overflow_out,
  output logic [LVL_W-1:0]  fifo_level_out
);

  localparam int                NUM_REGS = 2 * NUM_CH;
  localparam int                FIFO_W   = ADDR_W + WORD_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                busy_q;
  logic                overflow_q;
  logic [WORD_W-1:0]   rd_data_q;
  logic                rd_valid_q;
  logic [WORD_W-1:0]   shadow_q [NUM_REGS];
  logic [WORD_W-1:0]   active_q [NUM_REGS];
  logic [WORD_W-1:0]   rd_word;

  logic                pop;
  logic                copy_en;
  logic [FIFO_W-1:0]   fifo_dout;
  logic                fifo_full;
  logic                fifo_empty;
  logic [ADDR_W-1:0]   pop_addr;
  logic [WORD_W-1:0]   pop_data;

  assign pop_addr = fifo_dout[FIFO_W-1 -: ADDR_W];
  assign pop_data = fifo_dout[WORD_W-1:0];

  reg_write_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FIFO_W)
  ) u_fifo (
    .clk_i   (clk_in),
    .rst_ni  (reset_n_in),
    .push_i  (wr_valid_in),
    .data_i  ({wr_addr_in, wr_data_in}),
    .pop_i   (pop),
    .data_o  (fifo_dout),
    .level_o (fifo_level_out),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Next-state logic: drain in IDLE, wait for the frame tick, then copy with
  // engine reads taking the array port whenever they are requested.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pop     = 1'b0;
    copy_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (pop_addr == ADDR_COMMIT) state_d = WAIT_TICK;
        end
      end
      WAIT_TICK: begin
        if (sample_tick_in) begin
          state_d = COPY;
          idx_d   = '0;
        end
      end
      COPY: begin
        if (!rd_req_in) begin
          copy_en = 1'b1;
          if (idx_q == LAST_IDX) state_d = IDLE;
          else                   idx_d   = idx_q + ADDR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; busy is registered from the next state so it tracks the FSM exactly.
  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      state_q <= IDLE;
      idx_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  // Drained register writes land in the shadow bank; unmapped addresses fall through.
  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      for (int i = 0; i < NUM_REGS; i++) shadow_q[i] <= '0;
    end else if (pop) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (pop_addr == ADDR_W'(i)) shadow_q[i] <= pop_data;
      end
    end
  end

  // Active bank: written only by the commit copy, one word per granted cycle.
  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      for (int i = 0; i < NUM_REGS; i++) active_q[i] <= '0;
    end else if (copy_en) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (idx_q == ADDR_W'(i)) active_q[i] <= shadow_q[i];
      end
    end
  end

  // Engine read mux; addresses past the array return zero.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_addr_in == ADDR_W'(i)) rd_word = active_q[i];
    end
  end

  // Registered read port; data holds between reads.
  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_req_in;
      if (rd_req_in) rd_data_q <= rd_word;
    end
  end

  // Sticky overflow; a fresh drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      overflow_q <= 1'b0;
    end else if (wr_valid_in && fifo_full) begin
      overflow_q <= 1'b1;
    end else if (pop && (pop_addr == ADDR_OVF_CLR)) begin
      overflow_q <= 1'b0;
    end
  end

  assign rd_data_out     = rd_data_q;
  assign rd_valid_out    = rd_valid_q;
  assign commit_busy_out = busy_q;
  assign overflow_out    = overflow_q;

endmodule
